sr_pulse_scheduler: RTL

SR_PULSE_SCHEDULER -- requirements
Module: sr_pulse_scheduler

---
 rtl/sr_pulse_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sr_pulse_scheduler.sv
// sr_pulse_scheduler: round-robin S/R pulse sequencer for a bank of SR latches.
// Each set/reset request becomes one S or R pulse of PULSE_CYCLES cycles,
// followed by one settle cycle and a one-cycle ack.
// Optional readback check: define SR_SCHED_VERIFY_EN to add the CHECK state,
// the err output and comparison of the latch Q feedback.
module sr_pulse_scheduler #(
  parameter int N_FLAGS      = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_FLAGS-1:0] set_req,
  input  logic [N_FLAGS-1:0] rst_req,
  input  logic [N_FLAGS-1:0] q,
  output logic [N_FLAGS-1:0] S,
  output logic [N_FLAGS-1:0] R,
  output logic [N_FLAGS-1:0] set_ack,
  output logic [N_FLAGS-1:0] rst_ack,
`ifdef SR_SCHED_VERIFY_EN
  output logic               err,
`endif
  output logic               busy
);

  // Candidate 2i is "set flag i", candidate 2i+1 is "reset flag i".
  localparam int NC = 2 * N_FLAGS;
  localparam int PW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [PW:0]   NC_W       = (PW+1)'(NC);
  localparam logic [PW-1:0] LAST_IDX   = PW'(NC - 1);
  localparam logic [3:0]    PULSE_LOAD = 4'(PULSE_CYCLES);

`ifdef SR_SCHED_VERIFY_EN
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE} state_t;
`endif

  state_t             state_q;
  logic [PW-1:0]      ptr_q;
  logic [3:0]         cnt_q;
  logic [N_FLAGS-1:0] s_q, r_q, set_ack_q, rst_ack_q;
  logic [N_FLAGS-1:0] op_flag_q;
  logic               op_set_q;

  logic [NC-1:0]      cand;
  logic [NC-1:0]      win;
  logic               found;
  logic [PW-1:0]      off;
  logic [PW:0]        sum;
  logic [PW-1:0]      grant_idx;
  logic [PW-1:0]      next_ptr;
  logic [N_FLAGS-1:0] grant_flag;
  logic               grant_set;

  // Interleave the level requests into the candidate vector.
  generate
    for (genvar gi = 0; gi < N_FLAGS; gi++) begin : g_cand
      assign cand[2*gi]   = set_req[gi];
      assign cand[2*gi+1] = rst_req[gi];
      assign grant_flag[gi] = (grant_idx == PW'(2*gi)) || (grant_idx == PW'(2*gi+1));
    end
  endgenerate

  // Rotate candidates so the pointer position lands at bit 0.
  assign win = NC'({cand, cand} >> ptr_q);

  // Find the first active candidate at or after the pointer.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NC - 1; k >= 0; k--) begin
      if (win[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
    end
  end

  assign sum       = {1'b0, ptr_q} + {1'b0, off};
  assign grant_idx = (sum >= NC_W) ? PW'(sum - NC_W) : sum[PW-1:0];
  assign next_ptr  = (grant_idx == LAST_IDX) ? '0 : grant_idx + PW'(1);
  assign grant_set = ~grant_idx[0];

`ifdef SR_SCHED_VERIFY_EN
  logic err_q;
`else
  // Q feedback only matters when readback checking is built in.
  logic unused_q;
  assign unused_q = ^q;
`endif

  // Scheduler FSM: arbitration, pulse timing, ack generation and readback.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      s_q       <= '0;
      r_q       <= '0;
      set_ack_q <= '0;
      rst_ack_q <= '0;
      op_flag_q <= '0;
      op_set_q  <= 1'b0;
`ifdef SR_SCHED_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      set_ack_q <= '0;
      rst_ack_q <= '0;
`ifdef SR_SCHED_VERIFY_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q   <= PULSE;
            ptr_q     <= next_ptr;
            cnt_q     <= PULSE_LOAD;
            op_flag_q <= grant_flag;
            op_set_q  <= grant_set;
            s_q       <= grant_set ? grant_flag : '0;
            r_q       <= grant_set ? '0 : grant_flag;
          end
        end
        PULSE: begin
          if (cnt_q <= 4'd1) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
`ifndef SR_SCHED_VERIFY_EN
            set_ack_q <= op_set_q ? op_flag_q : '0;
            rst_ack_q <= op_set_q ? '0 : op_flag_q;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef SR_SCHED_VERIFY_EN
        SETTLE: begin
          // Q is sampled at the end of the settle cycle; result shows in CHECK.
          state_q   <= CHECK;
          set_ack_q <= op_set_q ? op_flag_q : '0;
          rst_ack_q <= op_set_q ? '0 : op_flag_q;
          err_q     <= ((|(q & op_flag_q)) != op_set_q);
        end
        CHECK: begin
          state_q <= IDLE;
        end
`else
        SETTLE: begin
          state_q <= IDLE;
        end
`endif
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign S       = s_q;
  assign R       = r_q;
  assign set_ack = set_ack_q;
  assign rst_ack = rst_ack_q;
  assign busy    = (state_q != IDLE);
`ifdef SR_SCHED_VERIFY_EN
  assign err     = err_q;
`endif

endmodule
